// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the instruction fetch controller
// and the PC register.
//   fetch_state_e  fetch FSM state encoding
//   INSTR_BYTES    PC increment per sequential instruction
//   RESET_PC       PC value after reset (used by the PC register)
//   MISALIGN_MASK  PC low bits that must be zero for a legal fetch
//   TMO_W          width of the imem ack timeout counter
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_HOLD,
      ST_DRAIN,
      ST_FAULT
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES   = 4;
   localparam logic [31:0] RESET_PC      = 32'h0040_0000;
   localparam logic [1:0]  MISALIGN_MASK = 2'b11;
   localparam int unsigned TMO_W         = 8;

   function automatic logic misaligned(input logic [1:0] pc_lsbs);
      return |(pc_lsbs & MISALIGN_MASK);
   endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: signal bundle around the fetch controller.
//   PC register side : pc_value (in), next_pc (out)
//   imem side        : imem_req/imem_addr (out), imem_ack/imem_rdata (in)
//   decode side      : instr_valid/instr/instr_pc (out), instr_ready (in)
//   control          : br_taken/br_target, redirect/redirect_pc (in),
//                      fetch_fault (out)
// Modport master is the fetch controller; slave is its environment.
interface instr_fetch_ctrl_if #(
   parameter int unsigned N = 32
);
   logic [N-1:0] pc_value;
   logic [N-1:0] next_pc;
   logic         imem_req;
   logic [N-1:0] imem_addr;
   logic         imem_ack;
   logic [N-1:0] imem_rdata;
   logic         instr_valid;
   logic         instr_ready;
   logic [N-1:0] instr;
   logic [N-1:0] instr_pc;
   logic         br_taken;
   logic [N-1:0] br_target;
   logic         redirect;
   logic [N-1:0] redirect_pc;
   logic         fetch_fault;

   modport master (
      input  pc_value, imem_ack, imem_rdata, instr_ready,
             br_taken, br_target, redirect, redirect_pc,
      output next_pc, imem_req, imem_addr, instr_valid,
             instr, instr_pc, fetch_fault
   );

   modport slave (
      output pc_value, imem_ack, imem_rdata, instr_ready,
             br_taken, br_target, redirect, redirect_pc,
      input  next_pc, imem_req, imem_addr, instr_valid,
             instr, instr_pc, fetch_fault
   );
endinterface

// File: rtl/fetch_timeout_cnt.sv
// fetch_timeout_cnt: 8-bit clear/enable counter that saturates at all-ones.
//   clk, rst_ni : clock, async active-low reset
//   clr_i       : synchronous clear (priority over en_i)
//   en_i        : count this cycle
//   expire_o    : this enabled cycle is the LIMIT-th since the last clear
module fetch_timeout_cnt
   import fetch_pkg::*;
#(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

   logic [TMO_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Count value 0 is the first cycle after clear, so LIMIT cycles end at LIMIT-1.
   assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch controller between the PC register and a
// multi-cycle instruction memory.
//   clk    : core clock
//   reset  : asynchronous active-low reset
//   bus    : instr_fetch_ctrl_if master (PC, imem req/ack, decode valid/ready,
//            branch/redirect inputs, sticky fetch_fault)
// next_pc holds pc_value except on a retire (branch target or PC+4) or a
// redirect (redirect_pc, highest priority).
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned N           = 32,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   instr_fetch_ctrl_if.master    bus
);
   fetch_state_e state_q;
   logic         req_q;
   logic         valid_q;
   logic         fault_q;
   logic [N-1:0] instr_q;
   logic [N-1:0] instr_pc_q;
   logic [N-1:0] next_pc_d;
   logic         tmo_clr;
   logic         tmo_en;
   logic         tmo_expire;

   // Counter is held clear outside REQ/DRAIN and re-cleared on REQ->DRAIN.
   assign tmo_en  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
   assign tmo_clr = !tmo_en ||
                    ((state_q == ST_REQ) && bus.redirect && !bus.imem_ack);

   fetch_timeout_cnt #(
      .LIMIT (ACK_TIMEOUT)
   ) u_tmo (
      .clk      (clk),
      .rst_ni   (reset),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expire_o (tmo_expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else if (bus.redirect) begin
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         // An outstanding request still owes a response; wait it out in DRAIN.
         state_q <= ((state_q == ST_REQ) && !bus.imem_ack) ? ST_DRAIN : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (misaligned(bus.pc_value[1:0])) begin
                  state_q <= ST_FAULT;
                  fault_q <= 1'b1;
               end else begin
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
               end
            end
            ST_REQ: begin
               if (bus.imem_ack) begin
                  state_q    <= ST_HOLD;
                  req_q      <= 1'b0;
                  valid_q    <= 1'b1;
                  instr_q    <= bus.imem_rdata;
                  instr_pc_q <= bus.pc_value;
               end else if (tmo_expire) begin
                  state_q <= ST_FAULT;
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.instr_ready) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (bus.imem_ack) begin
                  state_q <= ST_IDLE;
               end else if (tmo_expire) begin
                  state_q <= ST_FAULT;
                  fault_q <= 1'b1;
               end
            end
            ST_FAULT: begin
               state_q <= ST_FAULT;
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      next_pc_d = bus.pc_value;
      if (bus.redirect) begin
         next_pc_d = bus.redirect_pc;
      end else if (valid_q && bus.instr_ready) begin
         next_pc_d = bus.br_taken ? bus.br_target : bus.pc_value + N'(INSTR_BYTES);
      end
   end

   assign bus.next_pc     = next_pc_d;
   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = bus.pc_value;
   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
   import fetch_pkg::*;

   localparam int unsigned N   = 32;
   localparam int unsigned TMO = 8;

   logic clk = 1'b0;
   logic rst_n;
   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   instr_fetch_ctrl_if #(.N(N)) bus ();

   instr_fetch_ctrl #(
      .N           (N),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // PC register model: loads next_pc every cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.pc_value <= RESET_PC;
      else        bus.pc_value <= bus.next_pc;
   end

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        ready;
      logic        brt;
      logic [31:0] tgt;
      logic        e_req;
      logic        e_valid;
      logic [31:0] e_next;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_ipc;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(logic ack, logic [31:0] rdata, logic ready, logic brt,
                               logic [31:0] tgt, logic e_req, logic e_valid,
                               logic [31:0] e_next, logic [31:0] e_addr,
                               logic [31:0] e_instr, logic [31:0] e_ipc);
      vec_t v;
      v.ack = ack; v.rdata = rdata; v.ready = ready; v.brt = brt; v.tgt = tgt;
      v.e_req = e_req; v.e_valid = e_valid; v.e_next = e_next; v.e_addr = e_addr;
      v.e_instr = e_instr; v.e_ipc = e_ipc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = '0;
      bus.instr_ready = 1'b0;
      bus.br_taken    = 1'b0;
      bus.br_target   = '0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
   endtask

   initial begin
      int unsigned n;
      // Test 1: fetch at 0x400000, ack on 4th REQ cycle, immediate retire.
      vecs[0]  = mk(0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h400000, 32'h400000, 32'h0,        32'h0);
      vecs[1]  = mk(0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h400000, 32'h400000, 32'h0,        32'h0);
      vecs[2]  = mk(0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h400000, 32'h400000, 32'h0,        32'h0);
      vecs[3]  = mk(1, 32'h00500093, 0, 0, 32'h0,        1, 0, 32'h400000, 32'h400000, 32'h0,        32'h0);
      vecs[4]  = mk(0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h400004, 32'h400000, 32'h00500093, 32'h400000);
      vecs[5]  = mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h400004, 32'h400004, 32'h00500093, 32'h400000);
      // Test 2: taken branch on retire.
      vecs[6]  = mk(1, 32'h00A00113, 0, 0, 32'h0,        1, 0, 32'h400004, 32'h400004, 32'h00500093, 32'h400000);
      vecs[7]  = mk(0, 32'h0,        1, 1, 32'h400100,   0, 1, 32'h400100, 32'h400004, 32'h00A00113, 32'h400004);
      vecs[8]  = mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h400100, 32'h400100, 32'h00A00113, 32'h400004);
      vecs[9]  = mk(1, 32'h00000013, 0, 0, 32'h0,        1, 0, 32'h400100, 32'h400100, 32'h00A00113, 32'h400004);
      // Test 3: back-pressure for 5 cycles; br_* ignored while not retiring.
      vecs[10] = mk(0, 32'h0,        0, 1, 32'hDEADBEE0, 0, 1, 32'h400100, 32'h400100, 32'h00000013, 32'h400100);
      vecs[11] = mk(0, 32'h0,        0, 1, 32'hDEADBEE0, 0, 1, 32'h400100, 32'h400100, 32'h00000013, 32'h400100);
      vecs[12] = mk(0, 32'h0,        0, 1, 32'hDEADBEE0, 0, 1, 32'h400100, 32'h400100, 32'h00000013, 32'h400100);
      vecs[13] = mk(0, 32'h0,        0, 1, 32'hDEADBEE0, 0, 1, 32'h400100, 32'h400100, 32'h00000013, 32'h400100);
      vecs[14] = mk(0, 32'h0,        0, 1, 32'hDEADBEE0, 0, 1, 32'h400100, 32'h400100, 32'h00000013, 32'h400100);
      vecs[15] = mk(0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h400104, 32'h400100, 32'h00000013, 32'h400100);
      vecs[16] = mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h400104, 32'h400104, 32'h00000013, 32'h400100);

      rst_n = 1'b0;
      idle_in();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   32'(bus.imem_req),    32'h0);
      chk("rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_fault", 32'(bus.fetch_fault), 32'h0);
      chk("rst_instr", bus.instr,            32'h0);
      chk("rst_ipc",   bus.instr_pc,         32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         cyc();
         idle_in();
         bus.imem_ack    = vecs[i].ack;
         bus.imem_rdata  = vecs[i].rdata;
         bus.instr_ready = vecs[i].ready;
         bus.br_taken    = vecs[i].brt;
         bus.br_target   = vecs[i].tgt;
         #1;
         chk($sformatf("v%0d_req", i),   32'(bus.imem_req),    32'(vecs[i].e_req));
         chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_valid));
         chk($sformatf("v%0d_fault", i), 32'(bus.fetch_fault), 32'h0);
         chk($sformatf("v%0d_next", i),  bus.next_pc,          vecs[i].e_next);
         chk($sformatf("v%0d_addr", i),  bus.imem_addr,        vecs[i].e_addr);
         chk($sformatf("v%0d_instr", i), bus.instr,            vecs[i].e_instr);
         chk($sformatf("v%0d_ipc", i),   bus.instr_pc,         vecs[i].e_ipc);
      end

      // Test 4: redirect one cycle into REQ, late ack discarded in DRAIN.
      cyc(); idle_in(); #1;
      chk("t4_req0", 32'(bus.imem_req), 32'h1);
      chk("t4_addr0", bus.imem_addr, 32'h400104);
      cyc(); idle_in(); bus.redirect = 1'b1; bus.redirect_pc = 32'h400200; #1;
      chk("t4_rnext", bus.next_pc, 32'h400200);
      cyc(); idle_in(); #1;
      chk("t4_drain_req", 32'(bus.imem_req), 32'h0);
      chk("t4_drain_addr", bus.imem_addr, 32'h400200);
      cyc(); idle_in(); bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0BAD0BAD; #1;
      chk("t4_lateack_valid", 32'(bus.instr_valid), 32'h0);
      chk("t4_lateack_req", 32'(bus.imem_req), 32'h0);
      cyc(); idle_in(); #1;
      chk("t4_idle_valid", 32'(bus.instr_valid), 32'h0);
      chk("t4_instr_kept", bus.instr, 32'h00000013);
      cyc(); #1;
      chk("t4_newreq", 32'(bus.imem_req), 32'h1);
      chk("t4_newaddr", bus.imem_addr, 32'h400200);
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00000033;

      // HOLD with redirect and ready together: redirect wins over branch.
      cyc(); idle_in(); #1;
      chk("hr_valid", 32'(bus.instr_valid), 32'h1);
      chk("hr_instr", bus.instr, 32'h00000033);
      chk("hr_ipc", bus.instr_pc, 32'h400200);
      bus.instr_ready = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h400100;
      bus.redirect = 1'b1; bus.redirect_pc = 32'h400300; #1;
      chk("hr_next", bus.next_pc, 32'h400300);
      cyc(); idle_in(); #1;
      chk("hr_valid_drop", 32'(bus.instr_valid), 32'h0);
      chk("hr_pc", bus.imem_addr, 32'h400300);

      // REQ with redirect and ack together: data dropped, straight to IDLE.
      cyc(); #1;
      chk("ra_req", 32'(bus.imem_req), 32'h1);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h400400;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFFFFFF; #1;
      chk("ra_next", bus.next_pc, 32'h400400);
      cyc(); idle_in(); #1;
      chk("ra_valid", 32'(bus.instr_valid), 32'h0);
      chk("ra_instr", bus.instr, 32'h00000033);
      cyc(); #1;
      chk("ra_req_again", 32'(bus.imem_req), 32'h1);
      chk("ra_addr", bus.imem_addr, 32'h400400);

      // Test 5: branch to a misaligned PC -> FAULT, redirect recovers.
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00000013;
      cyc(); idle_in();
      bus.instr_ready = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h400002; #1;
      chk("t5_next", bus.next_pc, 32'h400002);
      cyc(); idle_in(); #1;
      chk("t5_idle_req", 32'(bus.imem_req), 32'h0);
      cyc(); #1;
      chk("t5_fault", 32'(bus.fetch_fault), 32'h1);
      chk("t5_noreq", 32'(bus.imem_req), 32'h0);
      chk("t5_hold_pc", bus.next_pc, 32'h400002);
      cyc(); #1;
      chk("t5_sticky", 32'(bus.fetch_fault), 32'h1);
      chk("t5_noreq2", 32'(bus.imem_req), 32'h0);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h400000; #1;
      chk("t5_rnext", bus.next_pc, 32'h400000);
      cyc(); idle_in(); #1;
      chk("t5_cleared", 32'(bus.fetch_fault), 32'h0);
      cyc(); #1;
      chk("t5_resume", 32'(bus.imem_req), 32'h1);
      chk("t5_addr", bus.imem_addr, 32'h400000);

      // Test 6: no ack -> exactly TMO cycles of request, then FAULT.
      n = 0;
      while (bus.imem_req && n < 40) begin
         n++;
         cyc();
      end
      chk("t6_req_cycles", n, TMO);
      chk("t6_fault", 32'(bus.fetch_fault), 32'h1);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h400000;
      cyc(); idle_in(); #1;
      chk("t6_cleared", 32'(bus.fetch_fault), 32'h0);
      cyc(); cyc(); #1;
      chk("t6_req_again", 32'(bus.imem_req), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req", 32'(bus.imem_req), 32'h0);
      chk("ar_valid", 32'(bus.instr_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ar_rel_req", 32'(bus.imem_req), 32'h0);
      cyc(); #1;
      chk("ar_idle_to_req", 32'(bus.imem_req), 32'h1);
      chk("ar_addr", bus.imem_addr, RESET_PC);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
